// File: rtl/core_mem_arbiter_if.sv
// Core-side request/ack signals and the shared AXI4 single-beat master channel.
// The master modport is the arbiter's view; the slave modport is the core plus memory.
interface core_mem_arbiter_if;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic        I_ACK;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [3:0]  D_STRB;
    logic        D_ACK;
    logic [31:0] RDATA;
    logic        BUS_ERR;

    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    modport master (
        input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_STRB,
        input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        output I_ACK, D_ACK, RDATA, BUS_ERR,
        output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_BREADY
    );

    modport slave (
        output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_STRB,
        output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
        input  I_ACK, D_ACK, RDATA, BUS_ERR,
        input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_BREADY
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter sharing one AXI4 single-beat master between instruction fetch
// and data access; one transaction in flight, all outputs registered.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transaction; pick a requester, launch AR or AW+W
// AR     | ARVALID held with ARADDR until ARREADY
// R      | RREADY held until RVALID; capture read data and RRESP
// AWW    | AWVALID/WVALID each held until their own handshake
// B      | BREADY held until BVALID; capture BRESP
// ACK    | one-cycle I_ACK or D_ACK (with BUS_ERR on a bad response)
module core_mem_arbiter #(
    parameter int          C_OFFSET_WIDTH = 28,
    parameter logic [31:0] C_BASE_ADDR    = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    core_mem_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B,
        S_ACK
    } state_t;

    // A width of 32 wraps the shift to zero, so the subtraction still yields all ones.
    localparam logic [31:0] OFFSET_MASK = (32'h1 << C_OFFSET_WIDTH) - 32'h1;

    function automatic logic [31:0] map_addr(input logic [31:0] addr);
        return C_BASE_ADDR | (addr & OFFSET_MASK & ~32'h3);
    endfunction

    state_t      state;
    logic        last_grant_data;
    logic        grant_data;
    logic        i_ack_q;
    logic        d_ack_q;
    logic        bus_err_q;
    logic [31:0] rdata_q;
    logic [31:0] araddr_q;
    logic        arvalid_q;
    logic        rready_q;
    logic [31:0] awaddr_q;
    logic        awvalid_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        wvalid_q;
    logic        bready_q;

    logic        aw_done;
    logic        w_done;

    // An address or data channel counts as finished if it already handshook or does so now.
    assign aw_done = !awvalid_q || bus.M_AXI_AWREADY;
    assign w_done  = !wvalid_q  || bus.M_AXI_WREADY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= S_IDLE;
            last_grant_data <= 1'b1;
            grant_data      <= 1'b0;
            i_ack_q         <= 1'b0;
            d_ack_q         <= 1'b0;
            bus_err_q       <= 1'b0;
            rdata_q         <= 32'h0;
            araddr_q        <= 32'h0;
            arvalid_q       <= 1'b0;
            rready_q        <= 1'b0;
            awaddr_q        <= 32'h0;
            awvalid_q       <= 1'b0;
            wdata_q         <= 32'h0;
            wstrb_q         <= 4'h0;
            wvalid_q        <= 1'b0;
            bready_q        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.I_REQ && (!bus.D_REQ || last_grant_data)) begin
                        grant_data      <= 1'b0;
                        last_grant_data <= 1'b0;
                        araddr_q        <= map_addr(bus.I_ADDR);
                        arvalid_q       <= 1'b1;
                        state           <= S_AR;
                    end else if (bus.D_REQ) begin
                        grant_data      <= 1'b1;
                        last_grant_data <= 1'b1;
                        if (bus.D_WE) begin
                            awaddr_q  <= map_addr(bus.D_ADDR);
                            wdata_q   <= bus.D_WDATA;
                            wstrb_q   <= bus.D_STRB;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= S_AWW;
                        end else begin
                            araddr_q  <= map_addr(bus.D_ADDR);
                            arvalid_q <= 1'b1;
                            state     <= S_AR;
                        end
                    end
                end

                S_AR: begin
                    if (bus.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_R;
                    end
                end

                S_R: begin
                    if (bus.M_AXI_RVALID) begin
                        rdata_q   <= bus.M_AXI_RDATA;
                        bus_err_q <= |bus.M_AXI_RRESP;
                        rready_q  <= 1'b0;
                        i_ack_q   <= !grant_data;
                        d_ack_q   <= grant_data;
                        state     <= S_ACK;
                    end
                end

                S_AWW: begin
                    if (bus.M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                    end
                    if (bus.M_AXI_WREADY) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state    <= S_B;
                    end
                end

                S_B: begin
                    if (bus.M_AXI_BVALID) begin
                        bus_err_q <= |bus.M_AXI_BRESP;
                        bready_q  <= 1'b0;
                        d_ack_q   <= 1'b1;
                        state     <= S_ACK;
                    end
                end

                S_ACK: begin
                    i_ack_q   <= 1'b0;
                    d_ack_q   <= 1'b0;
                    bus_err_q <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.I_ACK         = i_ack_q;
    assign bus.D_ACK         = d_ack_q;
    assign bus.BUS_ERR       = bus_err_q;
    assign bus.RDATA         = rdata_q;
    assign bus.M_AXI_ARADDR  = araddr_q;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_RREADY  = rready_q;
    assign bus.M_AXI_AWADDR  = awaddr_q;
    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = wstrb_q;
    assign bus.M_AXI_WVALID  = wvalid_q;
    assign bus.M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed bench for core_mem_arbiter: a word RAM slave with per-channel ready delays on
// one instance, and a hand-driven slave on a second instance with a non-zero base address.
module tb_core_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_mem_arbiter_if bus0 ();
    core_mem_arbiter_if bus1 ();

    core_mem_arbiter #(.C_OFFSET_WIDTH(28), .C_BASE_ADDR(32'h0000_0000)) dut0 (
        .CLK(clk), .RST(rst), .bus(bus0)
    );
    core_mem_arbiter #(.C_OFFSET_WIDTH(28), .C_BASE_ADDR(32'h4000_0000)) dut1 (
        .CLK(clk), .RST(rst), .bus(bus1)
    );

    int checks = 0;
    int errors = 0;

    // slave configuration, set by the test tasks
    int       ar_delay = 0;
    int       aw_delay = 0;
    int       w_delay  = 0;
    logic [1:0] rresp_cfg = 2'b00;

    logic [31:0] ram [64];

    // slave state
    logic        s_rst, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] ar_a, aw_a, w_d;
    logic [3:0]  w_s;
    logic        rd_pend, b_pend, got_aw, got_w;
    logic [5:0]  rd_idx, wr_idx;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          ar_cnt, aw_cnt, w_cnt;

    // Handshakes are sampled at the falling edge; slave outputs change 1 time unit after the rising edge.
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = (i < 8) ? i : 0;
        bus0.M_AXI_ARREADY = 1'b0; bus0.M_AXI_RDATA = 32'h0; bus0.M_AXI_RRESP = 2'b00;
        bus0.M_AXI_RVALID = 1'b0; bus0.M_AXI_AWREADY = 1'b0; bus0.M_AXI_WREADY = 1'b0;
        bus0.M_AXI_BRESP = 2'b00; bus0.M_AXI_BVALID = 1'b0;
        rd_pend = 0; b_pend = 0; got_aw = 0; got_w = 0; rd_idx = 0; wr_idx = 0;
        wd = 0; ws = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            ar_hs = bus0.M_AXI_ARVALID && bus0.M_AXI_ARREADY;
            r_hs  = bus0.M_AXI_RVALID && bus0.M_AXI_RREADY;
            aw_hs = bus0.M_AXI_AWVALID && bus0.M_AXI_AWREADY;
            w_hs  = bus0.M_AXI_WVALID && bus0.M_AXI_WREADY;
            b_hs  = bus0.M_AXI_BVALID && bus0.M_AXI_BREADY;
            ar_a  = bus0.M_AXI_ARADDR;
            aw_a  = bus0.M_AXI_AWADDR;
            w_d   = bus0.M_AXI_WDATA;
            w_s   = bus0.M_AXI_WSTRB;
            @(posedge clk);
            #1;
            if (s_rst) begin
                bus0.M_AXI_ARREADY = 1'b0; bus0.M_AXI_RVALID = 1'b0;
                bus0.M_AXI_AWREADY = 1'b0; bus0.M_AXI_WREADY = 1'b0; bus0.M_AXI_BVALID = 1'b0;
                rd_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (r_hs) bus0.M_AXI_RVALID = 1'b0;
                if (ar_hs) begin rd_pend = 1; rd_idx = ar_a[7:2]; end
                if (rd_pend && !bus0.M_AXI_RVALID) begin
                    bus0.M_AXI_RVALID = 1'b1;
                    bus0.M_AXI_RDATA  = ram[rd_idx];
                    bus0.M_AXI_RRESP  = rresp_cfg;
                    rd_pend = 0;
                end
                if (b_hs) bus0.M_AXI_BVALID = 1'b0;
                if (b_pend && !bus0.M_AXI_BVALID) begin
                    bus0.M_AXI_BVALID = 1'b1;
                    bus0.M_AXI_BRESP  = 2'b00;
                    b_pend = 0;
                end
                if (aw_hs) begin got_aw = 1; wr_idx = aw_a[7:2]; end
                if (w_hs) begin got_w = 1; wd = w_d; ws = w_s; end
                if (got_aw && got_w) begin
                    for (int b = 0; b < 4; b++)
                        if (ws[b]) ram[wr_idx][b*8 +: 8] = wd[b*8 +: 8];
                    got_aw = 0; got_w = 0; b_pend = 1;
                end
                if (bus0.M_AXI_ARVALID) begin bus0.M_AXI_ARREADY = (ar_cnt >= ar_delay); ar_cnt++; end
                else begin ar_cnt = 0; bus0.M_AXI_ARREADY = (ar_delay == 0); end
                if (bus0.M_AXI_AWVALID) begin bus0.M_AXI_AWREADY = (aw_cnt >= aw_delay); aw_cnt++; end
                else begin aw_cnt = 0; bus0.M_AXI_AWREADY = (aw_delay == 0); end
                if (bus0.M_AXI_WVALID) begin bus0.M_AXI_WREADY = (w_cnt >= w_delay); w_cnt++; end
                else begin w_cnt = 0; bus0.M_AXI_WREADY = (w_delay == 0); end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack0(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus0.I_ACK || bus0.D_ACK) && n < 64);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({bus0.I_ACK, bus0.D_ACK, bus0.BUS_ERR, bus0.M_AXI_ARVALID, bus0.M_AXI_RREADY,
             bus0.M_AXI_AWVALID, bus0.M_AXI_WVALID, bus0.M_AXI_BREADY} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b expected 00000000",
                     {bus0.I_ACK, bus0.D_ACK, bus0.BUS_ERR, bus0.M_AXI_ARVALID, bus0.M_AXI_RREADY,
                      bus0.M_AXI_AWVALID, bus0.M_AXI_WVALID, bus0.M_AXI_BREADY});
        end
        checks++;
        if ({bus0.M_AXI_ARADDR, bus0.M_AXI_AWADDR, bus0.M_AXI_WDATA, bus0.RDATA, bus0.M_AXI_WSTRB} !== 132'h0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0",
                     {bus0.M_AXI_ARADDR, bus0.M_AXI_AWADDR, bus0.M_AXI_WDATA, bus0.RDATA, bus0.M_AXI_WSTRB});
        end
    endtask

    // Zero-wait read: ARVALID the cycle after the request is sampled, I_ACK two cycles later.
    task automatic test_inst_read(input string tag);
        bus0.I_ADDR = 32'h10;
        bus0.I_REQ  = 1'b1;
        tick();
        checks++;
        if (bus0.M_AXI_ARVALID !== 1'b1 || bus0.M_AXI_ARADDR !== 32'h10) begin
            errors++;
            $display("FAIL %s_ar got valid=%b addr=%h expected valid=1 addr=00000010",
                     tag, bus0.M_AXI_ARVALID, bus0.M_AXI_ARADDR);
        end
        tick();
        checks++;
        if (bus0.I_ACK !== 1'b0 || bus0.M_AXI_RREADY !== 1'b1) begin
            errors++;
            $display("FAIL %s_r got ack=%b rready=%b expected ack=0 rready=1", tag, bus0.I_ACK, bus0.M_AXI_RREADY);
        end
        tick();
        checks++;
        if (bus0.I_ACK !== 1'b1 || bus0.D_ACK !== 1'b0 || bus0.RDATA !== 32'h4 || bus0.BUS_ERR !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack got iack=%b dack=%b rdata=%h err=%b expected 1 0 00000004 0",
                     tag, bus0.I_ACK, bus0.D_ACK, bus0.RDATA, bus0.BUS_ERR);
        end
        bus0.I_REQ = 1'b0;
        tick();
        checks++;
        if (bus0.I_ACK !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse got iack=%b expected 0", tag, bus0.I_ACK);
        end
    endtask

    task automatic test_round_robin();
        int  n;
        logic exp_inst;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus0.I_ADDR = 32'h10;
        bus0.D_ADDR = 32'h14;
        bus0.D_WE   = 1'b0;
        bus0.I_REQ  = 1'b1;
        bus0.D_REQ  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_inst = (k % 2 == 0);
            wait_ack0(n);
            checks++;
            if (n >= 64) begin
                errors++;
                $display("FAIL rr_timeout grant=%0d got no ack expected ack", k);
            end
            checks++;
            if (bus0.I_ACK !== exp_inst || bus0.D_ACK !== !exp_inst) begin
                errors++;
                $display("FAIL rr_grant%0d got iack=%b dack=%b expected iack=%b", k, bus0.I_ACK, bus0.D_ACK, exp_inst);
            end
            checks++;
            if (bus0.RDATA !== (exp_inst ? 32'h4 : 32'h5)) begin
                errors++;
                $display("FAIL rr_rdata%0d got %h expected %h", k, bus0.RDATA, exp_inst ? 32'h4 : 32'h5);
            end
            if (k == 4) begin
                bus0.I_REQ = 1'b0;
                bus0.D_REQ = 1'b0;
            end
        end
        tick();
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int exp_aw, input int exp_w);
        int t, awc, wc, bv_t, ack_t;
        logic [31:0] rd_before;
        rd_before = bus0.RDATA;
        bus0.D_ADDR  = addr;
        bus0.D_WE    = 1'b1;
        bus0.D_WDATA = data;
        bus0.D_STRB  = strb;
        bus0.D_REQ   = 1'b1;
        t = 0; awc = 0; wc = 0; bv_t = -1; ack_t = -1;
        while (ack_t < 0 && t < 64) begin
            tick();
            t++;
            if (t == 1) begin
                checks++;
                if (bus0.M_AXI_AWADDR !== addr || bus0.M_AXI_WDATA !== data || bus0.M_AXI_WSTRB !== strb) begin
                    errors++;
                    $display("FAIL %s_aw got addr=%h data=%h strb=%b expected %h %h %b",
                             tag, bus0.M_AXI_AWADDR, bus0.M_AXI_WDATA, bus0.M_AXI_WSTRB, addr, data, strb);
                end
            end
            if (bus0.M_AXI_AWVALID) awc++;
            if (bus0.M_AXI_WVALID) wc++;
            if (bus0.M_AXI_BVALID && bv_t < 0) bv_t = t;
            if (bus0.D_ACK) ack_t = t;
        end
        bus0.D_REQ = 1'b0;
        checks++;
        if (awc !== exp_aw || wc !== exp_w) begin
            errors++;
            $display("FAIL %s_valid_len got aw=%0d w=%0d expected aw=%0d w=%0d", tag, awc, wc, exp_aw, exp_w);
        end
        checks++;
        if (ack_t < 0 || bv_t < 0 || ack_t - bv_t != 1) begin
            errors++;
            $display("FAIL %s_b_to_ack got bvalid@%0d ack@%0d expected ack one cycle after bvalid", tag, bv_t, ack_t);
        end
        checks++;
        if (bus0.RDATA !== rd_before || bus0.BUS_ERR !== 1'b0 || bus0.I_ACK !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack_state got rdata=%h err=%b iack=%b expected rdata=%h err=0 iack=0",
                     tag, bus0.RDATA, bus0.BUS_ERR, bus0.I_ACK, rd_before);
        end
        tick();
    endtask

    task automatic do_data_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        int n;
        bus0.D_ADDR = addr;
        bus0.D_WE   = 1'b0;
        bus0.D_REQ  = 1'b1;
        wait_ack0(n);
        bus0.D_REQ = 1'b0;
        checks++;
        if (bus0.D_ACK !== 1'b1 || bus0.RDATA !== exp) begin
            errors++;
            $display("FAIL %s got dack=%b rdata=%h expected dack=1 rdata=%h", tag, bus0.D_ACK, bus0.RDATA, exp);
        end
        tick();
    endtask

    task automatic test_write();
        aw_delay = 3; w_delay = 0;
        do_write("wr_aw_slow", 32'h20, 32'hDEAD_BEEF, 4'b0011, 4, 1);
        do_data_read("rd_after_wr1", 32'h20, 32'h0000_BEEF);
        aw_delay = 0; w_delay = 2;
        do_write("wr_w_slow", 32'h24, 32'hCAFE_0000, 4'b1100, 1, 3);
        do_data_read("rd_after_wr2", 32'h24, 32'hCAFE_0000);
        w_delay = 0;
    endtask

    task automatic test_bus_err();
        int n;
        rresp_cfg = 2'b10;
        bus0.I_ADDR = 32'h08;
        bus0.I_REQ  = 1'b1;
        wait_ack0(n);
        bus0.I_REQ = 1'b0;
        checks++;
        if (n !== 3 || bus0.I_ACK !== 1'b1 || bus0.BUS_ERR !== 1'b1 || bus0.RDATA !== 32'h2) begin
            errors++;
            $display("FAIL err_ack got lat=%0d iack=%b err=%b rdata=%h expected 3 1 1 00000002",
                     n, bus0.I_ACK, bus0.BUS_ERR, bus0.RDATA);
        end
        tick();
        checks++;
        if (bus0.I_ACK !== 1'b0 || bus0.BUS_ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got iack=%b err=%b expected 0 0", bus0.I_ACK, bus0.BUS_ERR);
        end
        rresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid();
        int t;
        bus0.I_ADDR = 32'h10;
        bus0.I_REQ  = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!bus0.M_AXI_RREADY && t < 64);
        checks++;
        if (bus0.M_AXI_RREADY !== 1'b1) begin
            errors++;
            $display("FAIL mid_rready got %b expected 1", bus0.M_AXI_RREADY);
        end
        rst = 1'b1;
        bus0.I_REQ = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus0.I_ACK, bus0.D_ACK, bus0.BUS_ERR, bus0.M_AXI_ARVALID, bus0.M_AXI_RREADY,
             bus0.M_AXI_AWVALID, bus0.M_AXI_WVALID, bus0.M_AXI_BREADY} !== 8'h00 ||
            bus0.RDATA !== 32'h0 || bus0.M_AXI_ARADDR !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got ctrl=%b rdata=%h araddr=%h expected all 0",
                     {bus0.I_ACK, bus0.D_ACK, bus0.BUS_ERR, bus0.M_AXI_ARVALID, bus0.M_AXI_RREADY,
                      bus0.M_AXI_AWVALID, bus0.M_AXI_WVALID, bus0.M_AXI_BREADY}, bus0.RDATA, bus0.M_AXI_ARADDR);
        end
        test_inst_read("post_rst");
    endtask

    task automatic test_addr_base();
        bus0.D_ADDR = 32'hF000_0013;
        bus0.D_WE   = 1'b0;
        bus0.D_REQ  = 1'b1;
        tick();
        checks++;
        if (bus0.M_AXI_ARVALID !== 1'b1 || bus0.M_AXI_ARADDR !== 32'h0000_0010) begin
            errors++;
            $display("FAIL base0_araddr got valid=%b addr=%h expected 1 00000010", bus0.M_AXI_ARVALID, bus0.M_AXI_ARADDR);
        end
        tick();
        tick();
        bus0.D_REQ = 1'b0;
        checks++;
        if (bus0.D_ACK !== 1'b1 || bus0.RDATA !== 32'h4) begin
            errors++;
            $display("FAIL base0_ack got dack=%b rdata=%h expected 1 00000004", bus0.D_ACK, bus0.RDATA);
        end
        tick();

        bus1.D_ADDR = 32'hF000_0013;
        bus1.D_WE   = 1'b0;
        bus1.D_REQ  = 1'b1;
        tick();
        tick();
        checks++;
        if (bus1.M_AXI_ARVALID !== 1'b1 || bus1.M_AXI_ARADDR !== 32'h4000_0010) begin
            errors++;
            $display("FAIL base1_ar_hold got valid=%b addr=%h expected 1 40000010", bus1.M_AXI_ARVALID, bus1.M_AXI_ARADDR);
        end
        bus1.M_AXI_ARREADY = 1'b1;
        tick();
        bus1.M_AXI_ARREADY = 1'b0;
        checks++;
        if (bus1.M_AXI_ARVALID !== 1'b0 || bus1.M_AXI_RREADY !== 1'b1) begin
            errors++;
            $display("FAIL base1_r got arvalid=%b rready=%b expected 0 1", bus1.M_AXI_ARVALID, bus1.M_AXI_RREADY);
        end
        bus1.M_AXI_RDATA  = 32'h1234_5678;
        bus1.M_AXI_RRESP  = 2'b00;
        bus1.M_AXI_RVALID = 1'b1;
        tick();
        bus1.M_AXI_RVALID = 1'b0;
        bus1.D_REQ = 1'b0;
        checks++;
        if (bus1.D_ACK !== 1'b1 || bus1.RDATA !== 32'h1234_5678 || bus1.M_AXI_RREADY !== 1'b0) begin
            errors++;
            $display("FAIL base1_ack got dack=%b rdata=%h rready=%b expected 1 12345678 0",
                     bus1.D_ACK, bus1.RDATA, bus1.M_AXI_RREADY);
        end
        tick();
        checks++;
        if (bus1.D_ACK !== 1'b0) begin
            errors++;
            $display("FAIL base1_pulse got dack=%b expected 0", bus1.D_ACK);
        end
    endtask

    initial begin
        bus0.I_REQ = 1'b0; bus0.I_ADDR = 32'h0; bus0.D_REQ = 1'b0; bus0.D_WE = 1'b0;
        bus0.D_ADDR = 32'h0; bus0.D_WDATA = 32'h0; bus0.D_STRB = 4'h0;
        bus1.I_REQ = 1'b0; bus1.I_ADDR = 32'h0; bus1.D_REQ = 1'b0; bus1.D_WE = 1'b0;
        bus1.D_ADDR = 32'h0; bus1.D_WDATA = 32'h0; bus1.D_STRB = 4'h0;
        bus1.M_AXI_ARREADY = 1'b0; bus1.M_AXI_RDATA = 32'h0; bus1.M_AXI_RRESP = 2'b00;
        bus1.M_AXI_RVALID = 1'b0; bus1.M_AXI_AWREADY = 1'b0; bus1.M_AXI_WREADY = 1'b0;
        bus1.M_AXI_BRESP = 2'b00; bus1.M_AXI_BVALID = 1'b0;

        test_reset();
        test_inst_read("inst_rd");
        test_round_robin();
        test_write();
        test_bus_err();
        test_reset_mid();
        test_addr_base();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
Shares one AXI4 single-beat master port between the core's instruction fetch (read-only) and data access (read/write) requesters. It sits between the core and the memory-side AXI slave, replacing separate inst/data AXI masters. It does simple request/ack handshakes toward the core and full AXI4 valid/ready handshakes toward memory. It does round-robin arbitration, with one transaction outstanding at a time.

Parameters:
C_OFFSET_WIDTH, 28, number of low request-address bits forwarded to AXI; upper bits replaced by base
C_BASE_ADDR, 32'h0000_0000, OR'd into every AXI address above the offset field

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
I_REQ  in  1  instruction read request; held with I_ADDR stable until I_ACK
I_ADDR  in  32  instruction byte address
I_ACK  out  1  one-cycle pulse: instruction read done, RDATA valid this cycle
D_REQ  in  1  data request; held with D_* stable until D_ACK
D_WE  in  1  1=write, 0=read
D_ADDR  in  32  data byte address
D_WDATA  in  32  write data
D_STRB  in  4  byte strobes; ignored on reads
D_ACK  out  1  one-cycle pulse: data access done; RDATA valid this cycle on reads
RDATA  out  32  shared read-data register
BUS_ERR  out  1  pulses with the ACK when RRESP/BRESP != 2'b00
M_AXI_ARADDR  out  32  read address
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready
M_AXI_AWADDR  out  32  write address
M_AXI_AWVALID  out  1  write address valid
M_AXI_AWREADY  in  1  write address ready
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  write strobes
M_AXI_WVALID  out  1  write data valid
M_AXI_WREADY  in  1  write data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  write response valid
M_AXI_BREADY  out  1  write response ready

Behaviour:
- Reset: all outputs are registered and clear to 0, including addresses and RDATA. FSM goes to IDLE. last_grant = DATA, so the instruction port wins the first tie.
- FSM states: IDLE, AR, R, AWW, B, ACK.
- IDLE: if only one REQ is high, grant it. If both are high, grant the port opposite last_grant. Then update last_grant.
- IDLE transitions: instruction or data read goes to AR; data write goes to AWW.
- Address computation: AXI addr = C_BASE_ADDR | (addr[C_OFFSET_WIDTH-1:0] & ~32'h3). Addresses are word-aligned; low 2 bits are dropped.
- AR: ARVALID is high from the cycle after the grant. It holds with ARADDR stable until the ARREADY handshake, then goes to R.
- R: RREADY is high. On RVALID, latch RDATA and the error flag (RRESP != 0), drop RREADY, and go to ACK.
- AWW: AWVALID and WVALID rise together. Each drops independently on its own handshake. When both are done (in any order or the same cycle), go to B.
- B: BREADY is high. On BVALID, latch the error flag, drop BREADY, and go to ACK. RDATA is unchanged on writes.
- ACK: pulse I_ACK or D_ACK for exactly one cycle, with BUS_ERR if the error flag is set, then return to IDLE.
- Back-to-back requests: a REQ still high in the IDLE cycle after an ACK is a new request.
- Minimum latencies, with zero-wait slave:
  - read: REQ sampled at cycle N, ARVALID at N+1, RVALID at N+2, ACK at N+3
  - write: ACK at N+4
- No timeout; a slave that never responds stalls the FSM.
- A requester must not drop REQ before its ACK. If it does, the outcome is undefined, but the AXI transaction still completes.
- RST mid-transaction: at the next edge all VALID/READY signals drop and the FSM goes to IDLE. The in-flight AXI transaction is abandoned, and the slave shares RST.

Test Plan:
1. Inst read only: RAM[i]=i, I_ADDR=0x10, zero-wait slave, REQ at N -> ARADDR=0x10 at N+1; I_ACK at N+3 with RDATA=4, BUS_ERR=0.
2. I_REQ and D_REQ (read) both held from the first post-reset IDLE -> inst granted first, then data, then alternating: inst at 1st/3rd/5th grants, data at 2nd/4th.
3. Data write D_ADDR=0x20, D_WDATA=0xDEADBEEF, D_STRB=4'b0011, zero-initialised RAM, AWREADY delayed 3 cycles, WREADY zero-wait -> WVALID high 1 cycle, AWVALID high 4 cycles; D_ACK 1 cycle after BVALID; data read of 0x20 returns 0x0000BEEF.
4. Slave returns RRESP=2'b10 for an inst read -> I_ACK and BUS_ERR high in the same single cycle, RDATA = slave data.
5. RST pulsed while in R (RREADY=1) -> next cycle RREADY=0, all outputs 0; a subsequent I_REQ completes as in scenario 1.
6. D_ADDR=0xF000_0013, C_BASE_ADDR=0 -> ARADDR=0x0000_0010; with C_BASE_ADDR=32'h4000_0000 -> ARADDR=0x4000_0010.
